serial_subtractor: RTL and testbench

- Bit-serial, LSB-first subtractor. It computes a − b − bin on two WIDTH-bit operands, one bit per clock.
- Its datapath is a single full-subtractor cell with a registered borrow. It is the subtract-direction counterpart of the team's ripple full-adder datapath.
- It serves area-constrained arithmetic paths in the ALU. A start/done handshake sequences each operation.

---
 rtl/serial_subtractor.sv | 102 ++++++++++
 tb/tb_serial_subtractor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b - bin, one full-subtractor cell per clock.
// Revision 1.0 - initial release.
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic             d;
    logic             br_next;

    assign d       = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sh <= {d, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // d is the result MSB here, so overflow uses it directly.
                        diff  <= {d, res_sh[WIDTH-1:1]};
                        bout  <= br_next;
                        ovf   <= (a_msb ^ b_msb) & (d ^ a_msb);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int checks;
    int failures;

    logic [WIDTH-1:0] prev_diff;
    logic             prev_bout;
    logic             prev_ovf;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                         output logic [WIDTH-1:0] md, output logic mbo, output logic mov);
        int ua, ub, sa, sb, r;
        ua  = int'(ma);
        ub  = int'(mb);
        sa  = (ua >= 128) ? ua - 256 : ua;
        sb  = (ub >= 128) ? ub - 256 : ub;
        md  = WIDTH'((ua - ub - int'(mbin)) & 255);
        mbo = (ua < ub + int'(mbin));
        r   = sa - sb - int'(mbin);
        mov = (r < -128) || (r > 127);
    endtask

    // Drive start so it is accepted on the next rising edge; returns #1 after that edge.
    task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin);
        start = 1'b1;
        a     = ta;
        b     = tb;
        bin   = tbin;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom_range(255));
        b     = WIDTH'($urandom_range(255));
        bin   = 1'($urandom_range(1));
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // Wait for completion of the operation captured by start_op; optionally pokes start mid-run.
    task automatic wait_done(input string tag, input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                             input logic ebin, input int poke_at);
        logic [WIDTH-1:0] md;
        logic             mbo, mov;
        int               n;
        bit               seen;
        bit               held_ok;
        bit               busy_ok;
        model(ea, eb, ebin, md, mbo, mov);
        seen    = 0;
        held_ok = 1;
        busy_ok = 1;
        n       = 0;
        while (!seen && n < WIDTH + 3) begin
            @(posedge clk);
            #1;
            n++;
            if (n == poke_at) begin
                start = 1'b1;
                a     = 8'hFF;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
                a     = 8'h5C;
            end
            if (done) seen = 1;
            else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (diff !== prev_diff || bout !== prev_bout || ovf !== prev_ovf) held_ok = 0;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            check({tag, "_latency"}, n, WIDTH);
            check({tag, "_busy_during"}, {31'b0, busy_ok}, 32'd1);
            check({tag, "_result_held"}, {31'b0, held_ok}, 32'd1);
            check({tag, "_busy_low_at_done"}, {31'b0, busy}, 32'd0);
            check({tag, "_diff"}, {24'b0, diff}, {24'b0, md});
            check({tag, "_bout"}, {31'b0, bout}, {31'b0, mbo});
            check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, mov});
        end
        prev_diff = md;
        prev_bout = mbo;
        prev_ovf  = mov;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tbin);
        start_op(ta, tb, tbin);
        wait_done(tag, ta, tb, tbin, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rbin;
        bit               extra_done;

        checks    = 0;
        failures  = 0;
        prev_diff = '0;
        prev_bout = 1'b0;
        prev_ovf  = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_diff", {24'b0, diff}, 32'd0);
        check("reset_bout_ovf", {30'b0, bout, ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("basic", 8'h5A, 8'h3C, 1'b0);
        run_op("underflow", 8'h00, 8'h01, 1'b0);
        run_op("ovf_neg", 8'h80, 8'h01, 1'b0);
        run_op("bin_zero", 8'h10, 8'h0F, 1'b1);
        run_op("bin_borrow", 8'h0F, 8'h0F, 1'b1);

        // Restart attempt while busy must be ignored.
        start_op(8'h22, 8'h11, 1'b0);
        wait_done("ignore", 8'h22, 8'h11, 1'b0, 2);
        check("ignore_diff_const", {24'b0, diff}, 32'h11);
        extra_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) extra_done = 1;
        end
        check("ignore_no_second_done", {31'b0, extra_done}, 32'd0);
        check("ignore_idle", {31'b0, busy}, 32'd0);

        // Back-to-back: next start presented in the done cycle.
        start_op(8'h44, 8'h04, 1'b0);
        wait_done("b2b_first", 8'h44, 8'h04, 1'b0, 0);
        start_op(8'h03, 8'h05, 1'b0);
        wait_done("b2b_second", 8'h03, 8'h05, 1'b0, 0);
        check("b2b_diff_const", {24'b0, diff}, 32'hFE);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-operation.
        start_op(8'hC3, 8'h21, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_diff", {24'b0, diff}, 32'd0);
        check("arst_bout_ovf", {30'b0, bout, ovf}, 32'd0);
        prev_diff  = '0;
        prev_bout  = 1'b0;
        prev_ovf   = 1'b0;
        extra_done = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) extra_done = 1;
        end
        check("arst_no_done", {31'b0, extra_done}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("after_rst", 8'h7F, 8'hFF, 1'b1);

        // Randomized operations, some issued back-to-back.
        for (int i = 0; i < 40; i++) begin
            ra   = WIDTH'($urandom_range(255));
            rb   = WIDTH'($urandom_range(255));
            rbin = 1'($urandom_range(1));
            start_op(ra, rb, rbin);
            wait_done("rand", ra, rb, rbin, 0);
            if ($urandom_range(1) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
